// File: rtl/mdr_mem_interface_pkg.sv
// Purpose: shared encodings and default widths for the memory-side datapath slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdr_mem_interface_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;

    // Memory handshake FSM states; the bus and control unit decode the same values.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mdr_mem_interface_reg_ld.sv
// Purpose: generic width-parameterised register with load enable (MAR, MDR).
// Latency: q follows d one edge after en is sampled high.
// Backpressure: none; holds its value whenever en is low.
// Ports: clock, clear (async active-low), en, d -> q.
module reg_ld #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mdr_mem_interface.sv
// Purpose: MAR/MDR holding registers plus req/ack handshake to word-addressed memory.
// Latency: Read/Write sampled at edge N -> mem_req after N; earliest ack at N+1, done during N+1..N+2.
// Backpressure: waits on mem_ack up to TIMEOUT edges, then aborts with sticky err; bus loads ignored while waiting.
// Ports: clock/clear; BusMuxOut, MARin, MDRin, Read, Write from the datapath;
//        mem_rdata/mem_ack from memory; MDR_q to the bus; mem_addr/mem_wdata/mem_req/mem_we
//        to memory; busy/done/err status.
module mdr_mem_interface
    import mdr_mem_interface_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] MDR_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Abort happens on the edge that would take the count to TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    mem_state_t        state;
    logic [7:0]        wait_cnt;
    logic              load_window;
    logic              mar_en;
    logic              mdr_en;
    logic [DATA_W-1:0] mdr_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;

    // Bus loads are only honoured outside a transfer so MAR/MDR stay stable for memory.
    assign load_window = (state == IDLE) || (state == DONE);
    assign mar_en      = MARin && load_window;
    assign mdr_en      = (MDRin && load_window) || ((state == RD_WAIT) && mem_ack);
    assign mdr_d       = (state == RD_WAIT) ? mem_rdata : BusMuxOut;

    reg_ld #(.WIDTH(ADDR_W)) u_mar (
        .clock (clock),
        .clear (clear),
        .en    (mar_en),
        .d     (BusMuxOut[ADDR_W-1:0]),
        .q     (mar_q)
    );

    reg_ld #(.WIDTH(DATA_W)) u_mdr (
        .clock (clock),
        .clear (clear),
        .en    (mdr_en),
        .d     (mdr_d),
        .q     (mdr_q)
    );

    assign MDR_q     = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Read has priority when both strobes arrive together.
                    if (Read) begin
                        state    <= RD_WAIT;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        busy     <= 1'b1;
                    end else if (Write) begin
                        state    <= WR_WAIT;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Give up: MDR untouched, no done pulse, err latched until reset.
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_interface.sv
module tb_mdr_mem_interface;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              clear;
    logic [DATA_W-1:0] BusMuxOut;
    logic              MARin, MDRin, Read, Write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] MDR_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req, mem_we, busy, done, err;

    mdr_mem_interface #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .clear     (clear),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .MDR_q     (MDR_q),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          we;
        bit          timeout;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mdr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passed = 0;
    bit          sb_off = 1'b0;
    logic [31:0] mem[512];
    logic [8:0]  m_mar;
    logic [31:0] m_mdr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: compares the in-flight request and each transaction outcome.
    initial begin
        bit   pb;
        bit   pd;
        exp_t h;
        pb = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clock);
            if (!clear || sb_off) begin
                pb = 1'b0;
                pd = 1'b0;
            end else begin
                if (pd) chk("done_one_cycle", done, 0);
                if (busy) begin
                    if (sb.size() == 0) chk("busy_unexpected", 1, 0);
                    else begin
                        h = sb[0];
                        chk("wait_req", mem_req, 1);
                        chk("wait_we", mem_we, h.we);
                        chk("wait_addr", mem_addr, h.addr);
                        chk("wait_wdata", mem_wdata, h.wdata);
                    end
                end else if (pb) begin
                    if (sb.size() == 0) chk("end_unexpected", 1, 0);
                    else begin
                        h = sb.pop_front();
                        chk("end_req_low", mem_req, 0);
                        chk("end_done", done, h.timeout ? 0 : 1);
                        chk("end_mdr", MDR_q, h.mdr);
                        if (h.timeout) chk("timeout_err", err, 1);
                    end
                end
                pb = busy;
                pd = done;
            end
        end
    end

    task automatic load(input bit lmar, input bit lmdr, input logic [31:0] val);
        MARin = lmar; MDRin = lmdr; BusMuxOut = val;
        tick();
        MARin = 0; MDRin = 0;
        if (lmar) m_mar = val[8:0];
        if (lmdr) m_mdr = val;
    endtask

    task automatic clear_pokes();
        MARin = 0; MDRin = 0; Write = 0; Read = 0;
    endtask

    // dly < 0: memory never acks. Otherwise dly quiet wait edges, then the ack edge.
    task automatic do_txn(input bit rd, input bit wr, input int dly, input bit poke,
                          input bit lmar, input bit lmdr, input logic [31:0] bval);
        exp_t e;
        if (lmar) m_mar = bval[8:0];
        if (lmdr) m_mdr = bval;
        e.we      = !rd;
        e.timeout = (dly < 0);
        e.addr    = m_mar;
        e.wdata   = m_mdr;
        if (dly < 0) e.mdr = m_mdr;
        else if (rd) begin
            e.mdr = mem[m_mar];
            m_mdr = e.mdr;
        end else begin
            e.mdr = m_mdr;
            mem[m_mar] = m_mdr;
        end
        sb.push_back(e);
        Read = rd; Write = wr; MARin = lmar; MDRin = lmdr; BusMuxOut = bval;
        tick();
        clear_pokes();
        if (poke) begin
            MDRin = 1; MARin = 1; Write = 1; Read = 1; BusMuxOut = 32'd23;
        end
        if (dly < 0) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                tick();
                clear_pokes();
            end
        end else begin
            for (int i = 0; i < dly; i++) begin
                tick();
                clear_pokes();
            end
            mem_ack = 1;
            mem_rdata = rd ? e.mdr : $urandom;
            tick();
            clear_pokes();
            mem_ack = 0;
            mem_rdata = $urandom;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        bit rd, wr;
        int dly;
        clear = 0; BusMuxOut = 0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        mem_rdata = 0; mem_ack = 0;
        m_mar = 0; m_mdr = 0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[97] = 32'd8888;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mdr", MDR_q, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        clear = 1;
        tick();

        // Bus loads
        load(0, 1, 32'd12586);
        load(1, 0, 32'd97);
        chk("bus_mdr", MDR_q, 32'd12586);
        chk("bus_mar", mem_addr, 97);

        // Read of address 97, ack after 3 quiet cycles
        do_txn(1, 0, 3, 0, 0, 0, 0);
        chk("read_mdr", MDR_q, 32'd8888);

        // Write 732 to address 57, ack after 1 cycle
        load(0, 1, 32'd732);
        load(1, 0, 32'd57);
        do_txn(0, 1, 1, 0, 0, 0, 0);
        chk("write_mem", mem[57], 32'd732);

        // Timeout: no ack ever
        do_txn(1, 0, -1, 0, 0, 0, 0);
        chk("to_err", err, 1);
        chk("to_mdr", MDR_q, 32'd732);

        // Ack on the last permitted waiting edge, MAR loaded with Read; err stays set
        do_txn(1, 0, TIMEOUT - 1, 0, 1, 0, 32'd97);
        chk("late_ack_mdr", MDR_q, 32'd8888);
        chk("err_sticky", err, 1);

        // Read and Write together: read wins
        do_txn(1, 1, 2, 0, 0, 0, 0);

        // Bus loads and strobes during RD_WAIT ignored
        do_txn(1, 0, 4, 1, 1, 0, 32'd300);

        // Stray ack in IDLE
        mem_ack = 1; mem_rdata = 32'hdead_beef;
        tick();
        mem_ack = 0;
        tick();
        chk("stray_busy", busy, 0);
        chk("stray_req", mem_req, 0);
        chk("stray_done", done, 0);
        chk("stray_mdr", MDR_q, m_mdr);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            v = $urandom;
            if ($urandom_range(0, 3) == 0) load($urandom_range(0, 1), $urandom_range(0, 1), v);
            rd  = $urandom_range(0, 1);
            wr  = rd ? bit'($urandom_range(0, 1)) : 1'b1;
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
            v = $urandom;
            do_txn(rd, wr, dly, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1), $urandom_range(0, 1), v);
        end
        tick();
        chk("sb_drained", sb.size(), 0);
        chk("final_mdr", MDR_q, m_mdr);
        chk("final_mar", mem_addr, m_mar);

        // Asynchronous reset in the middle of a read
        sb_off = 1;
        load(1, 1, 32'h0000_5a5a);
        Read = 1;
        tick();
        Read = 0;
        chk("pre_rst_req", mem_req, 1);
        #2 clear = 0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_busy", busy, 0);
        chk("async_mdr", MDR_q, 0);
        chk("async_addr", mem_addr, 0);
        chk("async_err", err, 0);
        tick();
        clear = 1;
        tick();
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_done", done, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
